risc_host_loader: RTL
=====================

Name: risc_host_loader

Overview:
Host-side program/data loader that sits directly upstream of my_risc and owns its external memory port (Iaccess/Iwrb/Iaddr/Idata_in/Odata_out/Istart/O_done). It takes a 16-bit word stream from a host deserializer and executes three framed commands:
- WRITE: burst-load words into the 128-word memory.
- READ: stream memory words back to the host.
- RUN: pulse start, wait for done or timeout, then return a status word.

It replaces the hand-sequenced load/start/readback flow used at bench level.

Parameters:
TIMEOUT_CYCLES, 4096, RUN abort limit in clocks after the Ostart pulse (range 2..32767).
ADDR_W, 7, memory address width (128 words).
DATA_W, 16, word width.

Ports:
Iclk  in  1  clock, rising edge.
Ireset_n  in  1  asynchronous active-low reset.
Iin_valid  in  1  host input word valid.
Oin_ready  out  1  loader accepts input word.
Iin_data  in  16  host input word (header or payload).
Oout_valid  out  1  host output word valid.
Iout_ready  in  1  host accepts output word.
Oout_data  out  16  output word (read data or status).
Oaccess  out  1  to my_risc Iaccess: 1 = external port owns memory.
Owrb  out  1  to my_risc Iwrb: 0 = write, 1 = read.
Oaddr  out  7  to my_risc Iaddr.
Odata  out  16  to my_risc Idata_in.
Ostart  out  1  to my_risc Istart.
Irdata  in  16  from my_risc Odata_out.
Idone  in  1  from my_risc O_done (level).
Obusy  out  1  command in progress.
Oerr  out  1  one-cycle pulse on reserved command.

Behaviour:
- Reset values (asynchronous, any state, including mid-operation):
  - Oin_ready=0, Oout_valid=0, Oout_data=0.
  - Oaccess=1, Owrb=1, Oaddr=0, Odata=0, Ostart=0.
  - Obusy=0, Oerr=0.
  - State IDLE; pointers and counters cleared.
  - A memory write in flight is abandoned; no completion is required.
- All outputs are registered.
- Header word layout: [15:14] cmd, [13:7] count, [6:0] base.
  - cmd encoding: 00 WRITE, 01 READ, 10 RUN, 11 reserved.
  - count=0 means 128 words.
  - Count and base are ignored for RUN.
- Address pointer increments modulo 128 (127 wraps to 0).
- Input handshake: a transfer occurs on a clock edge where Iin_valid && Oin_ready.
- Output handshake: a transfer occurs on a clock edge where Oout_valid && Iout_ready. Oout_valid and Oout_data are held stable until the transfer.
- IDLE: Oin_ready=1, Obusy=0, Oaccess=1, Owrb=1. On header accept, decode cmd and set Obusy=1 from the next cycle.
  - 11 (reserved): Oerr=1 for exactly one cycle; stay in IDLE.
- WR_DATA: Oin_ready=1.
  - Each accepted word registers Oaddr=ptr, Odata=word, Owrb=0 for the following cycle, so memory sees a one-cycle write strobe.
  - Throughput is 1 word/clock; consecutive writes keep Owrb=0.
  - In a cycle with no accept, Owrb returns to 1.
  - After the last word: IDLE, with Owrb=1 on the next cycle.
- READ, per word:
  - RD_ADDR: Oin_ready=0; register Oaddr=ptr.
  - RD_SAMPLE: capture Irdata, valid one clock after the address is driven.
  - RD_SEND: Oout_valid=1 until accepted; then ptr++, remaining--, then RD_ADDR or IDLE.
  - Minimum 3 clocks/word; backpressure stalls indefinitely.
- RUN:
  - RUN_START: Oaccess=0, Owrb=1, Ostart=1 for exactly one cycle.
  - RUN_WAIT: Oaccess=0; a 15-bit cycle counter starts at 1.
    - Exit on a rising edge of Idone (0 then 1 on consecutive samples, first sample taken the cycle after Ostart), or when the counter reaches TIMEOUT_CYCLES.
    - If both happen in the same cycle, done wins.
    - A stale Idone held high across RUN_START is not a completion.
  - STAT_SEND: Oaccess=1. Oout_data={timeout_flag, cycles[14:0]}; Oout_valid until accepted; then IDLE.
- Oin_ready=0 in every state except IDLE and WR_DATA.

Decomposition:
- Package risc_loader_pkg:
  - cmd_e enum (CMD_WRITE, CMD_READ, CMD_RUN, CMD_RSVD).
  - state_e enum (IDLE, WR_DATA, RD_ADDR, RD_SAMPLE, RD_SEND, RUN_START, RUN_WAIT, STAT_SEND).
  - Header field bit-position constants; STAT_TIMEOUT_BIT=15.
- Sub-module risc_run_timer: counter, Idone edge detector, timeout compare. Outputs done_hit, timeout_hit, cycles.

Test Plan:
- WRITE 0x0140 then payload 5, 7 (back-to-back valid).
  - Owrb=0 on two consecutive cycles, Oaddr 64 then 65, Odata 5 then 7.
  - my_risc mem[64]=5, mem[65]=7.
- WRITE 0x0680 + the 13-word program, then RUN 0x8000.
  - Ostart high exactly 1 cycle with Oaccess=0.
  - On Idone rise, status bit15=0 and cycles>0.
  - Then READ 0x4240 returns 5, 7, 12, 7.
- RUN with TIMEOUT_CYCLES=16, Idone tied low → status word 0x8010; Oaccess returns to 1.
- WRITE 0x00FF (base 127, count 1) followed by WRITE 0x017F (base 127, count 2) with words A, B → writes at addr 127 then 0. READ 0x417F returns A, B.
- READ with Iout_ready low for 3 cycles → Oout_data stable across the stall; one word delivered per handshake. Header 0xC000 → Oerr single-cycle pulse, Obusy stays 0.
- Ireset_n asserted mid WR_DATA and mid RUN_WAIT → all outputs at reset values immediately, without waiting for a clock. Next header is accepted normally.

Source files
------------

// File: rtl/risc_loader_pkg.sv
// Shared types and header/status field positions for the host-side loader
// that drives my_risc's external memory port.
package risc_loader_pkg;

    typedef enum logic [1:0] {
        CMD_WRITE = 2'b00,
        CMD_READ  = 2'b01,
        CMD_RUN   = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        RD_ADDR,
        RD_SAMPLE,
        RD_SEND,
        RUN_START,
        RUN_WAIT,
        STAT_SEND
    } state_e;

    localparam int HDR_CMD_LSB      = 14;
    localparam int HDR_CMD_W        = 2;
    localparam int HDR_CNT_LSB      = 7;
    localparam int HDR_BASE_LSB     = 0;
    localparam int STAT_TIMEOUT_BIT = 15;
    localparam int CYCLE_W          = 15;

endpackage

// File: rtl/risc_host_loader_timer.sv
// RUN supervision: cycle counter, Idone rising-edge detector and timeout compare.
module risc_run_timer
    import risc_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm_i,
    input  logic               active_i,
    input  logic               done_i,
    output logic               done_hit_o,
    output logic               timeout_hit_o,
    output logic [CYCLE_W-1:0] cycles_o
);

    localparam logic [CYCLE_W-1:0] LIMIT = CYCLE_W'(TIMEOUT_CYCLES);

    logic [CYCLE_W-1:0] cnt_q;
    logic               done_prev_q;

    // Arming preloads the previous sample as high so a stale Idone that is
    // already asserted at start can never look like a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            done_prev_q <= 1'b0;
        end else if (arm_i) begin
            cnt_q       <= CYCLE_W'(1);
            done_prev_q <= 1'b1;
        end else if (active_i) begin
            cnt_q       <= cnt_q + CYCLE_W'(1);
            done_prev_q <= done_i;
        end
    end

    assign done_hit_o    = active_i && !done_prev_q && done_i;
    assign timeout_hit_o = active_i && (cnt_q == LIMIT);
    assign cycles_o      = cnt_q;

endmodule

// File: rtl/risc_host_loader.sv
// Host command engine (WRITE / READ / RUN) owning my_risc's external memory
// port; every output comes straight from a register.
module risc_host_loader
    import risc_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 16
) (
    input  logic              Iclk,
    input  logic              Ireset_n,
    input  logic              Iin_valid,
    output logic              Oin_ready,
    input  logic [DATA_W-1:0] Iin_data,
    output logic              Oout_valid,
    input  logic              Iout_ready,
    output logic [DATA_W-1:0] Oout_data,
    output logic              Oaccess,
    output logic              Owrb,
    output logic [ADDR_W-1:0] Oaddr,
    output logic [DATA_W-1:0] Odata,
    output logic              Ostart,
    input  logic [DATA_W-1:0] Irdata,
    input  logic              Idone,
    output logic              Obusy,
    output logic              Oerr
);

    state_e              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     rem_q;
    logic                in_ready_q, out_valid_q, access_q, wrb_q, start_q, busy_q, err_q;
    logic [DATA_W-1:0]   out_data_q, data_q;
    logic [ADDR_W-1:0]   addr_q;

    cmd_e                hdr_cmd;
    logic [ADDR_W-1:0]   hdr_cnt, hdr_base;
    logic                in_xfer, out_xfer, last_word;
    logic                done_hit, timeout_hit, run_arm, run_active;
    logic [CYCLE_W-1:0]  run_cycles;
    logic [DATA_W-1:0]   status_d;

    assign hdr_cmd   = cmd_e'(Iin_data[HDR_CMD_LSB +: HDR_CMD_W]);
    assign hdr_cnt   = Iin_data[HDR_CNT_LSB +: ADDR_W];
    assign hdr_base  = Iin_data[HDR_BASE_LSB +: ADDR_W];
    assign in_xfer   = Iin_valid && in_ready_q;
    assign out_xfer  = out_valid_q && Iout_ready;
    assign last_word = (rem_q == (ADDR_W+1)'(1));
    assign run_arm    = (state_q == RUN_START);
    assign run_active = (state_q == RUN_WAIT);

    always_comb begin
        status_d                   = '0;
        status_d[STAT_TIMEOUT_BIT] = !done_hit;
        status_d[CYCLE_W-1:0]      = run_cycles;
    end

    risc_run_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk          (Iclk),
        .rst_n        (Ireset_n),
        .arm_i        (run_arm),
        .active_i     (run_active),
        .done_i       (Idone),
        .done_hit_o   (done_hit),
        .timeout_hit_o(timeout_hit),
        .cycles_o     (run_cycles)
    );

    // Pulse-type outputs (Oerr, Ostart, write strobe) default to inactive each
    // cycle; the state branches below re-assert them where needed.
    always_ff @(posedge Iclk or negedge Ireset_n) begin
        if (!Ireset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            access_q    <= 1'b1;
            wrb_q       <= 1'b1;
            addr_q      <= '0;
            data_q      <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q   <= 1'b0;
            start_q <= 1'b0;
            wrb_q   <= 1'b1;
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_xfer) begin
                        ptr_q <= hdr_base;
                        rem_q <= {(hdr_cnt == '0), hdr_cnt};
                        case (hdr_cmd)
                            CMD_WRITE: begin
                                state_q <= WR_DATA;
                                busy_q  <= 1'b1;
                            end
                            CMD_READ: begin
                                state_q    <= RD_ADDR;
                                busy_q     <= 1'b1;
                                in_ready_q <= 1'b0;
                                addr_q     <= hdr_base;
                            end
                            CMD_RUN: begin
                                state_q    <= RUN_START;
                                busy_q     <= 1'b1;
                                in_ready_q <= 1'b0;
                                access_q   <= 1'b0;
                                start_q    <= 1'b1;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                WR_DATA: begin
                    if (in_xfer) begin
                        addr_q <= ptr_q;
                        data_q <= Iin_data;
                        wrb_q  <= 1'b0;
                        ptr_q  <= ptr_q + ADDR_W'(1);
                        rem_q  <= rem_q - (ADDR_W+1)'(1);
                        if (last_word) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                RD_ADDR:   state_q <= RD_SAMPLE;
                RD_SAMPLE: begin
                    out_data_q  <= Irdata;
                    out_valid_q <= 1'b1;
                    state_q     <= RD_SEND;
                end
                RD_SEND: begin
                    if (out_xfer) begin
                        out_valid_q <= 1'b0;
                        ptr_q       <= ptr_q + ADDR_W'(1);
                        rem_q       <= rem_q - (ADDR_W+1)'(1);
                        if (last_word) begin
                            state_q    <= IDLE;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q <= RD_ADDR;
                            addr_q  <= ptr_q + ADDR_W'(1);
                        end
                    end
                end
                RUN_START: state_q <= RUN_WAIT;
                RUN_WAIT: begin
                    if (done_hit || timeout_hit) begin
                        out_data_q  <= status_d;
                        out_valid_q <= 1'b1;
                        access_q    <= 1'b1;
                        state_q     <= STAT_SEND;
                    end
                end
                STAT_SEND: begin
                    if (out_xfer) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Oin_ready  = in_ready_q;
    assign Oout_valid = out_valid_q;
    assign Oout_data  = out_data_q;
    assign Oaccess    = access_q;
    assign Owrb       = wrb_q;
    assign Oaddr      = addr_q;
    assign Odata      = data_q;
    assign Ostart     = start_q;
    assign Obusy      = busy_q;
    assign Oerr       = err_q;

endmodule
